// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] EBREAK_WORD = 32'h0010_0073;
  localparam logic [XLEN-1:0] NOP_WORD    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect target or sequential pc+4 wrapped at the memory span.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 512
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  localparam int unsigned SUM_W = XLEN + 1;

  logic [SUM_W-1:0] seq_sum;
  logic [XLEN-1:0]  seq_pc;

  // Sequential successor; widened so the wrap compare cannot overflow.
  always_comb begin
    seq_sum = {1'b0, pc_i} + SUM_W'(4);
    seq_pc  = (seq_sum >= SUM_W'(IMEM_BYTES)) ? '0 : seq_sum[XLEN-1:0];
  end

  // Redirect wins over sequential flow; flag non-word-aligned targets.
  always_comb begin
    misaligned_o = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);
    next_pc_o    = redirect_valid_i ? redirect_target_i : seq_pc;
  end

endmodule : fetch_next_pc

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem address, fills the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES  = 512,
  parameter logic [31:0] EBREAK_WORD = fetch_pkg::EBREAK_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] read_address,
  input  logic [31:0] instr_in,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic        fetch_err
);

  import fetch_pkg::*;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc4_q, if_pc4_d;
  logic            halted_q, halted_d;
  logic            fetch_err_q, fetch_err_d;

  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            load;

  fetch_next_pc #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next_pc (
    .pc_i              (pc_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .next_pc_o         (next_pc),
    .misaligned_o      (misaligned)
  );

  assign load = !if_valid_q || if_ready;

  // State register and IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      if_pc4_q    <= '0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state: redirect (or misaligned error) beats load, load beats stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;

    unique case (state_q)
      IDLE: begin
        if (misaligned) begin
          if_valid_d  = 1'b0;
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = HALT;
        end else begin
          if (redirect_valid) pc_d = next_pc;
          if (start) state_d = RUN;
        end
      end
      RUN: begin
        if (misaligned) begin
          if_valid_d  = 1'b0;
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = HALT;
        end else if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_d       = next_pc;
        end else if (load) begin
          if_instr_d = instr_in;
          if_pc_d    = pc_q;
          if_pc4_d   = pc_q + XLEN'(4);
          if_valid_d = 1'b1;
          if (instr_in == EBREAK_WORD) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: begin
        // Let decode drain a presented ebreak; nothing else moves.
        if (if_valid_q && if_ready) if_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_address = pc_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc4_q;
  assign halted       = halted_q;
  assign fetch_err    = fetch_err_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] read_address;
  logic [31:0] instr_in;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic        fetch_err;

  logic        ebreak_en;
  int          n_checks;
  int          n_fail;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .read_address    (read_address),
    .instr_in        (instr_in),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .halted          (halted),
    .fetch_err       (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word[addr] = addr | 0xA000_0000, optional ebreak at 0x10.
  assign instr_in = (ebreak_en && read_address == 32'h10) ? 32'h0010_0073
                                                          : (read_address | 32'hA000_0000);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr"},  read_address,      32'h0);
    check({tag, ".valid"}, 32'(if_valid),     32'h0);
    check({tag, ".instr"}, if_instr,          32'h0);
    check({tag, ".pc"},    if_pc,             32'h0);
    check({tag, ".pc4"},   if_pc_plus4,       32'h0);
    check({tag, ".halt"},  32'(halted),       32'h0);
    check({tag, ".err"},   32'(fetch_err),    32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready = 1'b0;
    ebreak_en = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Sequential fetch
    if_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run.addr0", read_address, 32'h0);
    check("run.valid0", 32'(if_valid), 32'h0);
    tick();
    check("seq0.addr", read_address, 32'h4);
    check("seq0.pc", if_pc, 32'h0);
    check("seq0.valid", 32'(if_valid), 32'h1);
    check("seq0.instr", if_instr, 32'hA000_0000);
    tick();
    check("seq1.addr", read_address, 32'h8);
    check("seq1.pc", if_pc, 32'h4);
    check("seq1.instr", if_instr, 32'hA000_0004);
    check("seq1.pc4", if_pc_plus4, 32'h8);
    tick();
    check("seq2.pc", if_pc, 32'h8);
    check("seq2.addr", read_address, 32'hC);

    // Stall for three cycles
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", if_pc, 32'h8);
      check("stall.instr", if_instr, 32'hA000_0008);
      check("stall.addr", read_address, 32'hC);
      check("stall.valid", 32'(if_valid), 32'h1);
    end
    if_ready = 1'b1;
    tick();
    check("release.pc", if_pc, 32'hC);
    check("release.instr", if_instr, 32'hA000_000C);
    check("release.addr", read_address, 32'h10);

    // Redirect during a stall
    if_ready = 1'b0;
    tick();
    check("stall2.pc", if_pc, 32'hC);
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir.valid", 32'(if_valid), 32'h0);
    check("redir.addr", read_address, 32'h40);
    tick();
    check("redir.pc", if_pc, 32'h40);
    check("redir.v2", 32'(if_valid), 32'h1);
    check("redir.instr", if_instr, 32'hA000_0040);
    check("redir.addr2", read_address, 32'h44);
    if_ready = 1'b1;

    // Wrap at 512 bytes
    redirect_valid = 1'b1;
    redirect_target = 32'h1F8;
    tick();
    redirect_valid = 1'b0;
    check("wrap.addr0", read_address, 32'h1F8);
    tick();
    check("wrap.pc0", if_pc, 32'h1F8);
    check("wrap.addr1", read_address, 32'h1FC);
    tick();
    check("wrap.pc1", if_pc, 32'h1FC);
    check("wrap.pc4", if_pc_plus4, 32'h200);
    check("wrap.addr2", read_address, 32'h0);
    tick();
    check("wrap.pc2", if_pc, 32'h0);
    check("wrap.instr2", if_instr, 32'hA000_0000);

    // Ebreak at 0x10, decode stalls two cycles
    ebreak_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    check("ebk.addr", read_address, 32'h10);
    tick();
    check("ebk.halt", 32'(halted), 32'h1);
    check("ebk.instr", if_instr, 32'h0010_0073);
    check("ebk.valid", 32'(if_valid), 32'h1);
    check("ebk.pc", if_pc, 32'h10);
    check("ebk.addr1", read_address, 32'h10);
    tick();
    check("ebk.hold", if_instr, 32'h0010_0073);
    check("ebk.hvalid", 32'(if_valid), 32'h1);
    if_ready = 1'b1;
    tick();
    check("ebk.drain", 32'(if_valid), 32'h0);
    check("ebk.addr2", read_address, 32'h10);
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    start = 1'b1;
    tick();
    redirect_valid = 1'b0;
    start = 1'b0;
    check("ebk.ignore", read_address, 32'h10);
    check("ebk.ivalid", 32'(if_valid), 32'h0);
    check("ebk.err", 32'(fetch_err), 32'h0);
    tick();
    check("ebk.still", read_address, 32'h10);
    check("ebk.halt2", 32'(halted), 32'h1);

    // Misaligned redirect after a fresh reset
    ebreak_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst2");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mis.pre", if_pc, 32'h0);
    check("mis.prev", 32'(if_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_target = 32'h22;
    tick();
    redirect_valid = 1'b0;
    check("mis.err", 32'(fetch_err), 32'h1);
    check("mis.halt", 32'(halted), 32'h1);
    check("mis.valid", 32'(if_valid), 32'h0);
    check("mis.addr", read_address, 32'h4);
    tick();
    check("mis.sticky", 32'(fetch_err), 32'h1);
    check("mis.addr2", read_address, 32'h4);

    // Reset while halted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst3");
    tick();
    check("idle.addr", read_address, 32'h0);
    check("idle.valid", 32'(if_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the memory's byte read address. It captures the returned word into an IF/ID output register with a valid/ready handshake toward decode. It handles stall, branch/jump redirect with flush, ebreak halt, and misaligned-target error.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (byte address, multiple of 4)
IMEM_BYTES, 512, byte span of the instruction memory (128 words); PC wraps at this boundary
EBREAK_WORD, 32'h0010_0073, encoding that halts fetch

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching
redirect_valid  in  1  branch/jump taken; load redirect_target
redirect_target  in  32  new PC (byte address)
read_address  out  32  byte address to the instruction memory; equals pc register
instr_in  in  32  combinational read data from the instruction memory
if_valid  out  1  IF/ID register holds a valid instruction
if_ready  in  1  decode accepts the IF/ID contents this cycle
if_instr  out  32  captured instruction
if_pc  out  32  PC of if_instr
if_pc_plus4  out  32  if_pc + 4 (no wrap applied)
halted  out  1  fetch stopped (ebreak or error)
fetch_err  out  1  sticky; misaligned redirect seen

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset values: pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_err=0.
- read_address = pc at all times. Memory read is combinational, so instr_in is valid in the same cycle.
- States:
  - IDLE -> RUN when start=1.
  - RUN -> HALT when an EBREAK_WORD is loaded, or when a misaligned redirect is seen.
  - HALT: exit only via rst.
- load condition (RUN only): !if_valid || if_ready.
- RUN, redirect_valid=0, load=1:
  - if_instr<=instr_in, if_pc<=pc, if_valid<=1.
  - pc<=next_pc.
  - Latency: one cycle from address to if_instr. Throughput: one instruction per cycle.
- RUN, load=0 (stall): pc, if_instr, if_pc and if_valid all hold.
- RUN, redirect_valid=1 (highest priority, overrides load and stall):
  - if_valid<=0, flushing any held instruction.
  - pc<=redirect_target.
  - First post-redirect instruction appears 2 cycles after redirect asserts.
- Misaligned redirect (redirect_target[1:0]!=0) in any state except HALT:
  - pc unchanged, if_valid<=0, fetch_err<=1, halted<=1, state<=HALT.
- next_pc = pc+4. If pc+4 >= IMEM_BYTES, next_pc = 0 (wrap).
- EBREAK: when instr_in==EBREAK_WORD is loaded, halted<=1 and state<=HALT in the same edge.
  - The ebreak remains presented (if_valid=1) until if_ready, then if_valid<=0.
  - pc is not advanced past the ebreak.
- HALT: redirect_valid and start are ignored. No further loads.
- IDLE, aligned redirect_valid=1: pc<=redirect_target (boot-address programming).
  - If start=1 in the same cycle, RUN begins fetching from the redirected pc next cycle.
- rst asserted mid-operation (including during stall or HALT): full reset next edge. The in-flight instruction is discarded.
- if_pc_plus4 is registered alongside if_pc.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, RUN, HALT}
  - EBREAK_WORD and NOP_WORD (32'h0000_0013) constants
  - XLEN=32
- One natural combinational sub-module, fetch_next_pc: inputs pc, redirect_valid, redirect_target; outputs next pc and a misaligned flag. It implements the wrap rule.
- The remaining sequential logic (state register, IF/ID register, handshake) stays in fetch_unit.

Test Plan:
- Reset then start, if_ready=1, memory image word[addr]=addr|0xA000_0000 -> read_address sequence 0,4,8,...; if_pc lags by 1 cycle; if_instr=0xA000_0004 when if_pc=4.
- Hold if_ready=0 for 3 cycles with if_pc=8 -> if_instr, if_pc=8 and read_address=12 frozen; on release, next if_pc=12 with no skip or duplicate.
- redirect_valid=1, target=0x40, during a stall -> if_valid=0 next cycle, read_address=0x40, then if_pc=0x40 valid.
- Run from pc=0x1F8 -> sequence 0x1F8, 0x1FC, 0x000 (wrap at IMEM_BYTES=512).
- EBREAK_WORD at address 0x10, if_ready=0 for 2 cycles -> halted=1, if_instr=0x0010_0073 held; after accept, if_valid=0 and read_address stays 0x10; later redirect ignored.
- Redirect target 0x22 -> fetch_err=1, halted=1, if_valid=0; rst mid-HALT -> all outputs return to reset values, pc=RESET_PC.
